// File: rtl/ttl_pkg.sv
// Shared types and constants for the sampled-clock TTL counter models.
package ttl_pkg;

  localparam int LS93_B_WIDTH = 3;

  localparam logic CK_IDLE = 1'b1;

  typedef logic [3:0] ls93_q_t;

endpackage

// File: rtl/ttl_fall_det.sv
// Single-bit sampled falling-edge detector for TTL clock pins.
module ttl_fall_det
  import ttl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic fall
);

  logic d_q;
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= CK_IDLE;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= 1'b1;
    end
  end

  // A pin held low across reset release must not count as an edge.
  assign fall = armed & d_q & ~d;

endmodule

// File: rtl/ls93.sv
// 74LS93 4-bit ripple counter on one system clock.
// Define CLR_ASYNC_EN to force outputs low combinationally during clear.
module ls93
  import ttl_pkg::*;
#(
  parameter ls93_q_t INIT_Q = 4'b0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cka_n,
  input  logic ckb_n,
  input  logic r0_1,
  input  logic r0_2,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd
);

  logic    fall_a;
  logic    fall_b;
  logic    clr;
  ls93_q_t q_r;
  ls93_q_t q;

  ttl_fall_det u_det_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cka_n),
    .fall  (fall_a)
  );

  ttl_fall_det u_det_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ckb_n),
    .fall  (fall_b)
  );

  assign clr = r0_1 & r0_2;

  // Clear wins over any edge seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= INIT_Q;
    end else if (clr) begin
      q_r <= '0;
    end else begin
      if (fall_a)
        q_r[0] <= ~q_r[0];
      if (fall_b)
        q_r[LS93_B_WIDTH:1] <=
          q_r[LS93_B_WIDTH:1] + LS93_B_WIDTH'(1);
    end
  end

`ifdef CLR_ASYNC_EN
  assign q = clr ? '0 : q_r;
`else
  assign q = q_r;
`endif

  assign qa = q[0];
  assign qb = q[1];
  assign qc = q[2];
  assign qd = q[3];

endmodule

// File: tb/tb_ls93.sv
// Directed self-checking bench for ls93 (INIT_Q = 4'b0110).
module tb_ls93;

  logic clk = 1'b0;
  logic rst_n;
  logic cka_n;
  logic ckb_drv;
  logic loop_en;
  logic ckb_n;
  logic r0_1;
  logic r0_2;
  logic qa, qb, qc, qd;
  logic [3:0] q_obs;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ckb_n = loop_en ? qa : ckb_drv;
  assign q_obs = {qd, qc, qb, qa};

  ls93 #(.INIT_Q(4'b0110)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cka_n (cka_n),
    .ckb_n (ckb_n),
    .r0_1  (r0_1),
    .r0_2  (r0_2),
    .qa    (qa),
    .qb    (qb),
    .qc    (qc),
    .qd    (qd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    n_chk++;
    assert (q_obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, q_obs, exp);
    end
  endtask

  // One cka_n pulse with qa looped into ckb_n; c is the count before it.
  task automatic casc_step(input logic [3:0] c, input bit chk);
    logic [3:0] mid;
    logic [3:0] nxt;
    mid = {c[3:1], ~c[0]};
    nxt = c + 4'd1;
    cka_n = 1'b1;
    tick();
    cka_n = 1'b0;
    tick();
    if (chk) check("casc_mid", mid);
    tick();
    if (chk) check("casc_full", nxt);
  endtask

  initial begin
    rst_n   = 1'b0;
    cka_n   = 1'b0;
    ckb_drv = 1'b1;
    loop_en = 1'b0;
    r0_1    = 1'b0;
    r0_2    = 1'b0;
    tick();
    tick();
    check("reset", 4'b0110);

    rst_n = 1'b1;
    tick();
    tick();
    check("held_low", 4'b0110);
    cka_n = 1'b1;
    tick();
    check("rise", 4'b0110);
    cka_n = 1'b0;
    tick();
    check("first_fall", 4'b0111);

    for (int i = 0; i < 3; i++) begin
      cka_n = 1'b1;
      tick();
      tick();
      check("a_high", (i % 2 == 0) ? 4'b0111 : 4'b0110);
      cka_n = 1'b0;
      tick();
      check("a_fall", (i % 2 == 0) ? 4'b0110 : 4'b0111);
      tick();
      check("a_low", (i % 2 == 0) ? 4'b0110 : 4'b0111);
    end

    r0_1 = 1'b1;
    r0_2 = 1'b1;
    tick();
    check("clear", 4'b0000);
    r0_1 = 1'b0;
    r0_2 = 1'b0;

    cka_n = 1'b1;
    tick();
    cka_n = 1'b0;
    tick();
    check("pre_loop", 4'b0001);
    loop_en = 1'b1;
    r0_1 = 1'b1;
    r0_2 = 1'b1;
    tick();
    tick();
    check("loop_clear", 4'b0000);
    r0_1 = 1'b0;
    r0_2 = 1'b0;

    for (int c = 0; c < 16; c++)
      casc_step(4'(c), 1'b1);
    check("wrap", 4'b0000);

    for (int c = 0; c < 13; c++)
      casc_step(4'(c), 1'b0);
    check("at_13", 4'b1101);
    r0_1 = 1'b1;
    tick();
    check("r0_1_only", 4'b1101);
    cka_n = 1'b1;
    tick();
    check("r0_1_rise", 4'b1101);
    r0_2 = 1'b1;
    cka_n = 1'b0;
    tick();
    check("clr_vs_fall", 4'b0000);
    tick();
    check("clr_hold", 4'b0000);
    r0_1 = 1'b0;
    r0_2 = 1'b0;
    tick();
    check("edge_lost", 4'b0000);

    for (int c = 0; c < 15; c++)
      casc_step(4'(c), 1'b0);
    check("at_15", 4'b1111);
    r0_1 = 1'b1;
    r0_2 = 1'b1;
    #1;
`ifdef CLR_ASYNC_EN
    check("clr_same_cyc", 4'b0000);
`else
    check("clr_same_cyc", 4'b1111);
`endif
    tick();
    check("clr_next", 4'b0000);
    tick();
    check("clr_next2", 4'b0000);
    r0_1 = 1'b0;
    r0_2 = 1'b0;

    cka_n = 1'b1;
    tick();
    cka_n = 1'b0;
    tick();
    check("pre_rst", 4'b0001);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", 4'b0110);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst", 4'b0110);
    cka_n = 1'b1;
    tick();
    cka_n = 1'b0;
    tick();
    tick();
    check("resume", 4'b0111);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
